// File: rtl/fetch_stage_unit.sv
// Instruction-fetch stage with IF/ID register and a one-entry skid buffer for frozen cycles.
// Optional FETCH_PERF_CNT_EN adds stall/wait/flush event counters.
module fetch_stage_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  output logic              id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       wait_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] PC_RV = ADDR_W'(RESET_PC);

  typedef enum logic {
    FETCH    = 1'b0,
    BUFFERED = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] buf_pc;
  logic [DATA_W-1:0] buf_instr;

  // Memory handshake: a request is live whenever imem_req=1; imem_ready marks
  // the cycle in which imem_rdata carries the word for imem_addr. A request can
  // be abandoned by a redirect, so the memory must not assume completion.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc_next   = pc + INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= PC_RV;
      id_pc     <= '0;
      id_instr  <= '0;
      id_valid  <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else if (branch_taken) begin
      // Redirect drops the IF/ID word, the skid buffer and any same-cycle response.
      state     <= FETCH;
      pc        <= branch_addr;
      id_pc     <= '0;
      id_instr  <= '0;
      id_valid  <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_next;
            if (freeze) begin
              buf_pc    <= pc_next;
              buf_instr <= imem_rdata;
              state     <= BUFFERED;
            end else begin
              id_pc    <= pc_next;
              id_instr <= imem_rdata;
              id_valid <= 1'b1;
            end
          end else if (!freeze) begin
            id_pc    <= '0;
            id_instr <= '0;
            id_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (!freeze) begin
            id_pc    <= buf_pc;
            id_instr <= buf_instr;
            id_valid <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && !branch_taken) stall_cnt <= stall_cnt + 32'd1;
      if (state == FETCH && !imem_ready) wait_cnt <= wait_cnt + 32'd1;
      if (branch_taken) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Directed bench for fetch_stage_unit; memory returns 0xE0000000 + word index.
module tb_fetch_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] wait_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .wait_cnt     (wait_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign imem_rdata = 32'hE000_0000 + (imem_addr >> 2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid);
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_instr"}, id_instr, instr);
    check({tag, "_valid"}, {31'd0, id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_ready   = 1'b1;
    step();
    step();
    check_id("reset", 32'h0, 32'h0, 1'b0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b0;

    // Sequential fetch, one cycle behind the response
    for (int n = 0; n < 4; n++) begin
      step();
      check_id("seq", 32'(4 * (n + 1)), 32'hE000_0000 + 32'(n), 1'b1);
      check("seq_addr", imem_addr, 32'(4 * (n + 1)));
    end

    // Freeze three cycles with the word at 0x10 arriving in the first
    check("frz_req1", {31'd0, imem_req}, 32'd1);
    freeze = 1'b1;
    step();
    check("frz_req2", {31'd0, imem_req}, 32'd0);
    check_id("frz2", 32'h10, 32'hE000_0003, 1'b1);
    step();
    check("frz_req3", {31'd0, imem_req}, 32'd0);
    check_id("frz3", 32'h10, 32'hE000_0003, 1'b1);
    step();
    freeze = 1'b0;
    step();
    check_id("release", 32'h14, 32'hE000_0004, 1'b1);
    check("release_addr", imem_addr, 32'h14);
    check("release_req", {31'd0, imem_req}, 32'd1);
    for (int n = 5; n < 8; n++) begin
      step();
      check_id("post_frz", 32'(4 * (n + 1)), 32'hE000_0000 + 32'(n), 1'b1);
    end
    check("post_frz_addr", imem_addr, 32'h20);

    // Two wait cycles at 0x20
    imem_ready = 1'b0;
    step();
    check_id("wait1", 32'h0, 32'h0, 1'b0);
    check("wait1_addr", imem_addr, 32'h20);
    step();
    check_id("wait2", 32'h0, 32'h0, 1'b0);
    check("wait2_addr", imem_addr, 32'h20);
    imem_ready = 1'b1;
    step();
    check_id("wait_done", 32'h24, 32'hE000_0008, 1'b1);

    // Branch while BUFFERED and frozen
    freeze = 1'b1;
    step();
    check("buf_req", {31'd0, imem_req}, 32'd0);
    check_id("buf_hold", 32'h24, 32'hE000_0008, 1'b1);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    check_id("br", 32'h0, 32'h0, 1'b0);
    check("br_addr", imem_addr, 32'h100);
    check("br_req", {31'd0, imem_req}, 32'd1);
    branch_taken = 1'b0;
    freeze       = 1'b0;
    step();
    check_id("br_tgt", 32'h104, 32'hE000_0040, 1'b1);

    // Reset while BUFFERED and frozen
    freeze = 1'b1;
    step();
    check_id("buf2_hold", 32'h104, 32'hE000_0040, 1'b1);
    rst = 1'b1;
    step();
    check_id("rst_mid", 32'h0, 32'h0, 1'b0);
    check("rst_mid_addr", imem_addr, 32'h0);
    check("rst_mid_req", {31'd0, imem_req}, 32'd1);
    rst    = 1'b0;
    freeze = 1'b0;
    step();
    check_id("rst_after", 32'h4, 32'hE000_0000, 1'b1);

    // Freeze over a bubble keeps the bubble and loses nothing
    imem_ready = 1'b0;
    step();
    check_id("bub", 32'h0, 32'h0, 1'b0);
    freeze = 1'b1;
    step();
    check_id("bub_frz", 32'h0, 32'h0, 1'b0);
    check("bub_frz_addr", imem_addr, 32'h4);
    freeze     = 1'b0;
    imem_ready = 1'b1;
    step();
    check_id("bub_done", 32'h8, 32'hE000_0001, 1'b1);

    // PC wrap at the top of the address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    step();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step();
    check_id("wrap", 32'h0, 32'h1FFF_FFFF, 1'b1);
    check("wrap_addr1", imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1;
    step();
    check("cnt_rst_stall", stall_cnt, 32'd0);
    check("cnt_rst_wait", wait_cnt, 32'd0);
    check("cnt_rst_flush", flush_cnt, 32'd0);
    rst        = 1'b0;
    imem_ready = 1'b0;
    step();
    freeze = 1'b1;
    step();
    step();
    freeze       = 1'b0;
    imem_ready   = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    step();
    branch_taken = 1'b0;
    step();
    check("cnt_stall", stall_cnt, 32'd2);
    check("cnt_wait", wait_cnt, 32'd3);
    check("cnt_flush", flush_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
